pool1_maxpool: RTL
==================

Name: pool1_maxpool

Overview:
- 2x2/stride-2 max-pooling stage for LeNet layer 1.
- Reads the six 28x28 conv1 feature maps from the f2 feature-map RAM through its shared read address; that RAM has 2-cycle read latency.
- Writes six 14x14 pooled maps into the downstream f3 RAM with a shared write address and write enable.
- One start pulse processes one full frame.

Parameters:
- DW, 16, sample width, signed two's-complement fixed point
- IN_W, 28, input map width and height (square)
- OUT_W, 14, output map width and height (IN_W/2)
- RD_LAT, 2, f2 RAM read latency in cycles
- RAW, 10, f2 read address width
- WAW, 8, f3 write address width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle frame start request
- f2_raddr  out  RAW  f2 read address (shared by 6 maps)
- f2_1_rdata..f2_6_rdata  in  DW each  f2 read data, valid RD_LAT cycles after address
- f3_wr_en  out  1  f3 write enable
- f3_waddr  out  WAW  f3 write address, 0..195
- f3_1_wdata..f3_6_wdata  out  DW each  pooled results, one per map
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: all outputs and internal state are 0; FSM goes to IDLE. Reset is asynchronous and may hit mid-frame.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE when start=1 at a clock edge.
  - ISSUE -> DRAIN after the 784th read address is driven.
  - DRAIN -> DONE once the last write has been emitted.
  - DONE -> IDLE after one cycle.
- start is ignored in every state except IDLE.
- Read order in ISSUE: one read per cycle, no gaps.
  - Windows in raster order: orow 0..13, ocol 0..13.
  - Within a window, beats b=0..3 read (2*orow,2*ocol), (2*orow,2*ocol+1), (2*orow+1,2*ocol), (2*orow+1,2*ocol+1).
  - f2_raddr = row*28 + col. Compute it without a multiplier: keep a row-base register, stepped by +28/+56.
- Latency tracking: a valid/beat-tag shift register RD_LAT deep runs alongside each issued address. Data for the beat issued in cycle t is sampled in cycle t+2.
- Max per map:
  - Beat 0 loads the running max.
  - Beats 1..2 update it: max = (rdata > max) ? rdata : max, as a signed DW-bit compare.
  - On beat 3 the final max (including beat 3) is registered into f3_n_wdata. In the next cycle f3_wr_en=1 and f3_waddr = window index (orow*14+ocol).
  - Ties keep the existing value. No saturation or rounding needed.
- Frame timing, with start sampled at edge k:
  - ISSUE covers cycles k..k+783 (f2_raddr 0,1,28,29,2,3,30,31,...).
  - First f3_wr_en in cycle k+6. Writes occur every 4th cycle, 196 in total; the last is in cycle k+786.
  - done=1 in cycle k+787 only.
  - busy=1 in cycles k..k+786; it is 0 in the done cycle and in IDLE.
- f3_wr_en is high for exactly one cycle per window. f3_waddr and f3_wdata hold their last value when f3_wr_en=0.
- f2_raddr holds its last value outside ISSUE.
- Reset mid-frame: the frame is abandoned, no done pulse, and no further writes. The next start begins a clean frame at window 0.
- A start arriving in the done cycle is ignored. A start in the first IDLE cycle after done begins a new frame.

Decomposition:
- Shared package lenet_pkg holds:
  - DW
  - map dimensions 28/14/10 (conv2 output)
  - map count 6
  - RD_LAT
  - address widths RAW/WAW
  - FSM state encoding for pool1_maxpool
- Sub-module pool1_addr_gen: row/col/beat counters, f2_raddr generation, last-read flag.
- Max datapath (6 lanes) and FSM stay in the top module.

Test Plan:
- Ramp: f2 map n holds (addr + n*1000); one start -> 196 writes, waddr w = orow*14+ocol, map-n data = (2*orow+1)*28 + 2*ocol+1 + n*1000; done in cycle k+787.
- Signed: window holding {-5,-3,-32768,-4} -> -3; window {32767,-1,0,1} -> 32767; window all -7 -> -7.
- Max position: per window, place the maximum at beat 0, 1, 2, then 3 in successive windows -> the correct max each time (checks beat-tag alignment with 2-cycle latency).
- start pulses while busy and in the done cycle -> ignored: exactly 196 writes, one done; back-to-back start one cycle after done -> second frame identical to the first.
- Assert rst at cycle k+400 -> all outputs 0 immediately, no done, no writes; new start -> full correct frame.
- Protocol checks over all frames: f3_wr_en count = 196 per frame; f2_raddr covers each of 0..783 exactly once per frame.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet constants, sample type and pool1 FSM encoding; no logic, no latency.
// Stages using it stream at fixed rate with no backpressure.
package lenet_pkg;

    localparam int DW      = 16;
    localparam int IN_W    = 28;
    localparam int OUT_W   = 14;
    localparam int C2_W    = 10;
    localparam int N_MAPS  = 6;
    localparam int RD_LAT  = 2;
    localparam int RAW     = 10;
    localparam int WAW     = 8;
    localparam int IN_PIX  = IN_W * IN_W;
    localparam int OUT_PIX = OUT_W * OUT_W;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        P1_IDLE  = 2'd0,
        P1_ISSUE = 2'd1,
        P1_DRAIN = 2'd2,
        P1_DONE  = 2'd3
    } pool1_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] beat;
    } rd_tag_t;

    function automatic sample_t smax(input sample_t cur, input sample_t cand);
        return (cand > cur) ? cand : cur;
    endfunction

endpackage

// File: rtl/pool1_maxpool_if.sv
// Frame control, shared f2 read port and f3 write port of the pool1 stage.
// Pure wiring: zero latency, no backpressure (fixed-rate RAM ports).
interface pool1_maxpool_if;
    import lenet_pkg::*;

    logic           start;
    logic [RAW-1:0] f2_raddr;
    sample_t        f2_1_rdata;
    sample_t        f2_2_rdata;
    sample_t        f2_3_rdata;
    sample_t        f2_4_rdata;
    sample_t        f2_5_rdata;
    sample_t        f2_6_rdata;
    logic           f3_wr_en;
    logic [WAW-1:0] f3_waddr;
    sample_t        f3_1_wdata;
    sample_t        f3_2_wdata;
    sample_t        f3_3_wdata;
    sample_t        f3_4_wdata;
    sample_t        f3_5_wdata;
    sample_t        f3_6_wdata;
    logic           busy;
    logic           done;

    modport master (
        input  start,
        input  f2_1_rdata, f2_2_rdata, f2_3_rdata, f2_4_rdata, f2_5_rdata, f2_6_rdata,
        output f2_raddr,
        output f3_wr_en, f3_waddr,
        output f3_1_wdata, f3_2_wdata, f3_3_wdata, f3_4_wdata, f3_5_wdata, f3_6_wdata,
        output busy, done
    );

    modport slave (
        output start,
        output f2_1_rdata, f2_2_rdata, f2_3_rdata, f2_4_rdata, f2_5_rdata, f2_6_rdata,
        input  f2_raddr,
        input  f3_wr_en, f3_waddr,
        input  f3_1_wdata, f3_2_wdata, f3_3_wdata, f3_4_wdata, f3_5_wdata, f3_6_wdata,
        input  busy, done
    );

endinterface

// File: rtl/pool1_addr_gen.sv
// Walks 2x2 windows in raster order, one registered f2 address per advance (1-cycle update).
// No backpressure: advance is the only stall; clear restarts at window 0.
module pool1_addr_gen
    import lenet_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           advance,
    output logic [RAW-1:0] raddr,
    output logic [1:0]     beat,
    output logic           last
);

    logic [3:0]     ocol;
    logic [3:0]     orow;
    logic [RAW-1:0] row_base;

    logic [1:0]     beat_n;
    logic [3:0]     ocol_n;
    logic [3:0]     orow_n;
    logic [RAW-1:0] row_base_n;
    logic [RAW-1:0] raddr_n;

    // row_base tracks 2*orow*IN_W so no multiplier is needed
    always_comb begin
        beat_n     = beat + 2'd1;
        ocol_n     = ocol;
        orow_n     = orow;
        row_base_n = row_base;
        if (beat == 2'd3) begin
            if (ocol == 4'(OUT_W - 1)) begin
                ocol_n     = '0;
                orow_n     = orow + 4'd1;
                row_base_n = row_base + RAW'(2 * IN_W);
            end else begin
                ocol_n = ocol + 4'd1;
            end
        end
        raddr_n = row_base_n
                + (beat_n[1] ? RAW'(IN_W) : '0)
                + RAW'({ocol_n, 1'b0})
                + RAW'(beat_n[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat     <= '0;
            ocol     <= '0;
            orow     <= '0;
            row_base <= '0;
            raddr    <= '0;
        end else if (clear) begin
            beat     <= '0;
            ocol     <= '0;
            orow     <= '0;
            row_base <= '0;
            raddr    <= '0;
        end else if (advance) begin
            beat     <= beat_n;
            ocol     <= ocol_n;
            orow     <= orow_n;
            row_base <= row_base_n;
            raddr    <= raddr_n;
        end
    end

    assign last = (beat == 2'd3) && (ocol == 4'(OUT_W - 1)) && (orow == 4'(OUT_W - 1));

endmodule

// File: rtl/pool1_maxpool.sv
// 2x2/stride-2 max pool over six 28x28 maps; first f3 write 6 cycles after start, done at +787.
// No backpressure: one f2 read per cycle, one f3 write every 4th cycle.
module pool1_maxpool
    import lenet_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    pool1_maxpool_if.master bus
);

    pool1_state_t   state;
    logic           busy_q;
    logic           done_q;
    logic           issue;
    logic           start_ok;
    logic           last;
    logic [1:0]     beat;

    rd_tag_t        tag_pipe [RD_LAT];
    rd_tag_t        smp;

    sample_t        rdata   [N_MAPS];
    sample_t        run_max [N_MAPS];
    sample_t        wdata   [N_MAPS];
    logic           wr_en;
    logic [WAW-1:0] waddr;
    logic [WAW-1:0] wcnt;

    assign issue    = (state == P1_ISSUE);
    assign start_ok = (state == P1_IDLE) && bus.start;

    pool1_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .advance (issue && !last),
        .raddr   (bus.f2_raddr),
        .beat    (beat),
        .last    (last)
    );

    assign rdata[0] = bus.f2_1_rdata;
    assign rdata[1] = bus.f2_2_rdata;
    assign rdata[2] = bus.f2_3_rdata;
    assign rdata[3] = bus.f2_4_rdata;
    assign rdata[4] = bus.f2_5_rdata;
    assign rdata[5] = bus.f2_6_rdata;

    // Beat tag travels with the address so it lines up with returning RAM data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{vld: issue, beat: beat};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign smp = tag_pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_MAPS; n++) begin
                run_max[n] <= '0;
                wdata[n]   <= '0;
            end
            wr_en <= 1'b0;
            waddr <= '0;
            wcnt  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                wcnt <= '0;
            end
            if (smp.vld) begin
                for (int n = 0; n < N_MAPS; n++) begin
                    case (smp.beat)
                        2'd0:    run_max[n] <= rdata[n];
                        2'd3:    wdata[n]   <= smax(run_max[n], rdata[n]);
                        default: run_max[n] <= smax(run_max[n], rdata[n]);
                    endcase
                end
                if (smp.beat == 2'd3) begin
                    wr_en <= 1'b1;
                    waddr <= wcnt;
                    wcnt  <= wcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= P1_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                P1_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= P1_ISSUE;
                        busy_q <= 1'b1;
                    end
                end
                P1_ISSUE: begin
                    if (last) begin
                        state <= P1_DRAIN;
                    end
                end
                P1_DRAIN: begin
                    if (wr_en && (waddr == WAW'(OUT_PIX - 1))) begin
                        state  <= P1_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= P1_IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.f3_wr_en   = wr_en;
    assign bus.f3_waddr   = waddr;
    assign bus.f3_1_wdata = wdata[0];
    assign bus.f3_2_wdata = wdata[1];
    assign bus.f3_3_wdata = wdata[2];
    assign bus.f3_4_wdata = wdata[3];
    assign bus.f3_5_wdata = wdata[4];
    assign bus.f3_6_wdata = wdata[5];

endmodule
